fx2_out_reader: RTL and testbench

FX2_OUT_READER -- requirements
Module: fx2_out_reader

---
 rtl/fx2_pkg.sv | 27 ++
 rtl/fx2_rx_fifo.sv | 63 ++++++
 rtl/fx2_out_reader.sv | 161 ++++++++++++++++
 tb/tb_fx2_out_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_pkg.sv
// Shared FX2 slave-FIFO definitions: FSM encoding,
// endpoint addresses and default buffer depth.
package fx2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_READ = 2'd2
  } fx2_state_e;

  localparam logic [1:0] FX2_EP2_ADDR = 2'b00;
  localparam logic [1:0] FX2_EP6_ADDR = 2'b10;

  localparam int FX2_DEPTH_DEF = 4;
  localparam int FX2_DW        = 16;

  // Read strobe may only fire with room for the
  // word on this edge plus one more, because the
  // FX2 empty flag lags a read by one cycle.
  function automatic logic fx2_room2(
    input int unsigned depth,
    input int unsigned count
  );
    return (depth - count) >= 2;
  endfunction

endpackage

// File: rtl/fx2_rx_fifo.sv
// Synchronous receive FIFO with head-word output.
// Ports: i_push/i_wdata, i_pop/o_rdata, o_count,
// o_full, o_empty. o_rdata is 0 while empty.
module fx2_rx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fx2_out_reader.sv
// FX2 slave-FIFO EP2 OUT reader feeding a
// valid/ready stream through a small buffer.
// Ports: fx2_* slave FIFO pins; rx_enable gates
// reading; out_data/out_valid/out_ready stream;
// rx_count words read; err_count/err_flag pattern
// checker results (FX2_OUT_PATTERN_CHECK_EN,
// else tied to zero).
module fx2_out_reader
  import fx2_pkg::*;
#(
  parameter int         DEPTH   = FX2_DEPTH_DEF,
  parameter logic [1:0] EP_ADDR = FX2_EP2_ADDR
) (
  input  logic        fx2_ifclk,
  input  logic        reset_n,
  input  logic [15:0] fx2_fdata,
  output logic [1:0]  fx2_faddr,
  input  logic        fx2_flagb,
  output logic        fx2_slrd,
  output logic        fx2_sloe,
  output logic        fx2_slwr,
  output logic        fx2_pkt_end,
  input  logic        rx_enable,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rx_count,
  output logic [15:0] err_count,
  output logic        err_flag
);

  localparam int CW = $clog2(DEPTH) + 1;

  fx2_state_e    r_state;
  fx2_state_e    w_state_nxt;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_room;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   r_rx_count;

  assign fx2_faddr   = EP_ADDR;
  assign fx2_slwr    = 1'b1;
  assign fx2_pkt_end = 1'b1;

  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (rx_enable) w_state_nxt = ST_ARM;
      ST_ARM:  w_state_nxt = ST_READ;
      ST_READ: if (!rx_enable) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_room = ~w_full &
    fx2_room2(DEPTH, 32'(w_count));

  // Strobe is combinational so the empty flag
  // cancels a read in the same cycle it drops.
  always_comb begin
    fx2_sloe = 1'b1;
    fx2_slrd = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        fx2_sloe = 1'b1;
      end
      ST_ARM: begin
        fx2_sloe = 1'b0;
      end
      ST_READ: begin
        fx2_sloe = 1'b0;
        fx2_slrd = ~(fx2_flagb & w_room);
      end
      default: begin
        fx2_sloe = 1'b1;
      end
    endcase
  end

  assign w_push    = ~fx2_slrd;
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;

  fx2_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .i_clk   (fx2_ifclk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_wdata (fx2_fdata),
    .i_pop   (w_pop),
    .o_rdata (out_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_count <= '0;
    end else if (w_push) begin
      r_rx_count <= r_rx_count + 32'd1;
    end
  end

  assign rx_count = r_rx_count;

`ifdef FX2_OUT_PATTERN_CHECK_EN
  logic        r_first;
  logic [15:0] r_expect;
  logic [15:0] r_err_count;
  logic        r_err_flag;
  logic        w_mis;

  // The first word after ARM only seeds the
  // expected value; later words are compared.
  assign w_mis = w_push & ~r_first &
    (fx2_fdata != r_expect);

  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      r_first     <= 1'b1;
      r_expect    <= '0;
      r_err_count <= '0;
      r_err_flag  <= 1'b0;
    end else begin
      if (r_state == ST_ARM) begin
        r_first <= 1'b1;
      end else if (w_push) begin
        r_first  <= 1'b0;
        r_expect <= fx2_fdata + 16'd1;
      end
      if (w_mis) begin
        r_err_flag <= 1'b1;
        if (r_err_count != 16'hFFFF) begin
          r_err_count <= r_err_count + 16'd1;
        end
      end
    end
  end

  assign err_count = r_err_count;
  assign err_flag  = r_err_flag;
`else
  assign err_count = '0;
  assign err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_fx2_out_reader.sv
// Directed bench for fx2_out_reader with a
// behavioural FX2 EP2 source and stream checker.
module tb_fx2_out_reader;

`ifdef FX2_OUT_PATTERN_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] fx2_fdata;
  logic [1:0]  fx2_faddr;
  logic        fx2_flagb;
  logic        fx2_slrd;
  logic        fx2_sloe;
  logic        fx2_slwr;
  logic        fx2_pkt_end;
  logic        rx_enable;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rx_count;
  logic [15:0] err_count;
  logic        err_flag;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] fx_mem [0:1023];
  int fx_idx = 0;
  int fx_len = 0;
  bit fx_clr = 1'b1;
  bit flag_en = 1'b0;
  int exp_idx = 0;

  always #5 clk = ~clk;

  fx2_out_reader dut (
    .fx2_ifclk   (clk),
    .reset_n     (reset_n),
    .fx2_fdata   (fx2_fdata),
    .fx2_faddr   (fx2_faddr),
    .fx2_flagb   (fx2_flagb),
    .fx2_slrd    (fx2_slrd),
    .fx2_sloe    (fx2_sloe),
    .fx2_slwr    (fx2_slwr),
    .fx2_pkt_end (fx2_pkt_end),
    .rx_enable   (rx_enable),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rx_count    (rx_count),
    .err_count   (err_count),
    .err_flag    (err_flag)
  );

  assign fx2_flagb = flag_en && (fx_idx < fx_len);
  assign fx2_fdata = fx_mem[fx_idx % 1024];

  always @(posedge clk) begin
    if (fx_clr) fx_idx <= 0;
    else if (!fx2_slrd) fx_idx <= fx_idx + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_idx = fx_idx;
    end else if (out_valid && out_ready) begin
      chk("word", 32'(out_data),
          32'(fx_mem[exp_idx % 1024]));
      exp_idx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    fx_clr    = 1'b1;
    rx_enable = 1'b0;
    out_ready = 1'b0;
    flag_en   = 1'b0;
    tick();
    fx_clr = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_idx(
    input int    target,
    input int    budget,
    input string tag
  );
    int n = 0;
    while (exp_idx < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_idx), 32'(target));
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, "_valid"}, 32'(out_valid), 0);
    chk({t, "_data"}, 32'(out_data), 0);
    chk({t, "_rxcnt"}, rx_count, 0);
    chk({t, "_errc"}, 32'(err_count), 0);
    chk({t, "_errf"}, 32'(err_flag), 0);
    chk({t, "_slrd"}, 32'(fx2_slrd), 1);
    chk({t, "_sloe"}, 32'(fx2_sloe), 1);
  endtask

  initial begin
    int k;
    reset_n   = 1'b0;
    rx_enable = 1'b1;
    out_ready = 1'b1;
    flag_en   = 1'b1;
    fx_len    = 10;
    tick();
    tick();
    chk_reset_vals("rst");
    chk("faddr", 32'(fx2_faddr), 0);
    chk("slwr", 32'(fx2_slwr), 1);
    chk("pktend", 32'(fx2_pkt_end), 1);

    // streaming 0..511
    do_reset();
    for (int i = 0; i < 512; i++) fx_mem[i] = 16'(i);
    fx_len = 512;
    flag_en = 1'b1;
    out_ready = 1'b1;
    rx_enable = 1'b1;
    wait_idx(512, 2000, "stream_done");
    chk("stream_rxcnt", rx_count, 512);
    chk("stream_errc", 32'(err_count), 0);
    chk("stream_fxidx", 32'(fx_idx), 512);

    // backpressure
    do_reset();
    for (int i = 0; i < 64; i++)
      fx_mem[i] = 16'h1000 + 16'(i);
    fx_len = 64;
    flag_en = 1'b1;
    rx_enable = 1'b1;
    repeat (20) tick();
    chk("bp_reads", 32'(fx_idx), 3);
    chk("bp_slrd", 32'(fx2_slrd), 1);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_hold", 32'(out_data), 32'h1000);
    chk("bp_rxcnt", rx_count, 3);
    out_ready = 1'b1;
    wait_idx(64, 500, "bp_done");
    chk("bp_rxcnt2", rx_count, 64);

    // EP2 empty after word 100
    do_reset();
    for (int i = 0; i < 200; i++)
      fx_mem[i] = 16'h0200 + 16'(i);
    fx_len = 101;
    flag_en = 1'b1;
    out_ready = 1'b1;
    rx_enable = 1'b1;
    k = 0;
    while (fx_idx < 101 && k < 500) begin
      tick();
      k++;
    end
    chk("empty_idx", 32'(fx_idx), 101);
    chk("empty_slrd", 32'(fx2_slrd), 1);
    repeat (10) tick();
    chk("empty_hold", 32'(fx_idx), 101);
    chk("empty_rxcnt", rx_count, 101);
    chk("empty_drain", 32'(exp_idx), 101);
    fx_len = 200;
    wait_idx(200, 500, "empty_resume");
    chk("empty_rxcnt2", rx_count, 200);

    // enable toggling
    do_reset();
    for (int i = 0; i < 1000; i++)
      fx_mem[i] = 16'h3000 + 16'(i);
    fx_len = 1000;
    flag_en = 1'b1;
    out_ready = 1'b1;
    rx_enable = 1'b1;
    repeat (30) tick();
    k = fx_idx;
    rx_enable = 1'b0;
    tick();
    chk("en_last_rd", 32'(fx_idx), 32'(k + 1));
    tick();
    chk("en_sloe", 32'(fx2_sloe), 1);
    chk("en_slrd", 32'(fx2_slrd), 1);
    repeat (5) tick();
    chk("en_stop", 32'(fx_idx), 32'(k + 1));
    chk("en_empty", 32'(out_valid), 0);
    chk("en_drain", 32'(exp_idx), 32'(k + 1));
    out_ready = 1'b0;
    rx_enable = 1'b1;
    repeat (10) tick();
    chk("en2_reads", 32'(fx_idx), 32'(k + 4));
    rx_enable = 1'b0;
    repeat (3) tick();
    chk("en2_sloe", 32'(fx2_sloe), 1);
    chk("en2_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("en2_empty", 32'(out_valid), 0);
    chk("en2_drain", 32'(exp_idx), 32'(k + 4));

    // reset mid-transfer
    do_reset();
    fx_len = 1000;
    flag_en = 1'b1;
    out_ready = 1'b1;
    rx_enable = 1'b1;
    repeat (20) tick();
    out_ready = 1'b0;
    repeat (6) tick();
    reset_n = 1'b0;
    tick();
    chk_reset_vals("mrst");
    k = fx_idx;
    reset_n = 1'b1;
    tick();
    chk("mrst_keep", 32'(fx_idx), 32'(k));
    out_ready = 1'b1;
    fx_len = k + 50;
    wait_idx(k + 50, 500, "mrst_done");
    chk("mrst_rxcnt", rx_count, 50);

    // pattern checker 5,6,7,9,10
    do_reset();
    fx_mem[0] = 16'd5;
    fx_mem[1] = 16'd6;
    fx_mem[2] = 16'd7;
    fx_mem[3] = 16'd9;
    fx_mem[4] = 16'd10;
    fx_len = 5;
    flag_en = 1'b1;
    out_ready = 1'b1;
    rx_enable = 1'b1;
    wait_idx(5, 200, "pat_done");
    chk("pat_errc", 32'(err_count), 32'(EXP_ERR));
    chk("pat_errf", 32'(err_flag), 32'(EXP_ERR));
    chk("pat_rxcnt", rx_count, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
